sfr_timer_bank: RTL and testbench

Parametrised special-function register bank for the Mini-CPU. It holds NUM_PORTS data-direction (TRIS) registers and the OPTION register, and adds the OPTION-controlled TMR0 timer/counter with a programmable prescaler and a sticky overflow flag. All registers are written from the W bus under single-cycle strobes from the instruction decoder. Outputs feed the port pad logic and the file-register read mux.

---
 rtl/sfr_timer_bank.sv | 107 ++++++++++
 tb/tb_sfr_timer_bank.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/sfr_timer_bank.sv
`default_nettype none
// sfr_timer_bank: TRIS/OPTION special-function registers plus the TMR0 timer/counter
// with prescaler, write-inhibit window and sticky overflow flag. Revision 1.0.
module sfr_timer_bank #(
  parameter int                DATA_W    = 8,
  parameter int                NUM_PORTS = 2,
  parameter logic [DATA_W-1:0] TRIS_RST  = '1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_W-1:0]             W,
  input  logic [NUM_PORTS-1:0]          tris_wr,
  input  logic                          option_wr,
  input  logic                          tmr0_wr,
  input  logic                          cyc_en,
  input  logic                          t0cki,
  input  logic                          t0if_clr,
  output logic [NUM_PORTS*DATA_W-1:0]   TRIS,
  output logic [DATA_W-1:0]             OPTION,
  output logic [DATA_W-1:0]             TMR0,
  output logic                          T0IF
);

  logic [DATA_W-1:0] tris_q [NUM_PORTS];
  logic [DATA_W-1:0] option_q, option_d;
  logic [DATA_W-1:0] tmr0_q, tmr0_d;
  logic              t0if_q, t0if_d;
  logic [7:0]        ps_q, ps_d;
  logic [1:0]        inh_q, inh_d;
  logic              sync1_q, sync2_q, prev_q;
  logic              edge_q, edge_d;

  logic       tick;
  logic       tick_en;
  logic       inc;
  logic       ovf;
  logic [8:0] ps_lim;
  logic [7:0] ps_max;

  generate
    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_tris
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)            tris_q[i] <= TRIS_RST;
        else if (tris_wr[i]) tris_q[i] <= W;
      end
      assign TRIS[i*DATA_W +: DATA_W] = tris_q[i];
    end
  endgenerate

  always_comb begin
    tick     = option_q[5] ? edge_q : cyc_en;
    tick_en  = tick && (inh_q == 2'd0);
    // Terminal prescaler count is 2^(PS+1)-1; the 9-bit form keeps PS=7 at 0xFF.
    ps_lim   = (9'd2 << option_q[2:0]) - 9'd1;
    ps_max   = ps_lim[7:0];
    inc      = 1'b0;
    ps_d     = ps_q;
    if (tick_en) begin
      if (option_q[3]) begin
        inc = 1'b1;
      end else if (ps_q == ps_max) begin
        ps_d = 8'd0;
        inc  = 1'b1;
      end else begin
        ps_d = ps_q + 8'd1;
      end
    end
    if (option_q[3] || option_wr || tmr0_wr) ps_d = 8'd0;

    inh_d    = tmr0_wr ? 2'd2 : ((inh_q != 2'd0) ? inh_q - 2'd1 : 2'd0);
    tmr0_d   = tmr0_wr ? W : (inc ? tmr0_q + DATA_W'(1) : tmr0_q);
    ovf      = inc && !tmr0_wr && (tmr0_q == '1);
    t0if_d   = ovf ? 1'b1 : (t0if_clr ? 1'b0 : t0if_q);
    option_d = option_wr ? W : option_q;
    edge_d   = option_q[4] ? (prev_q & ~sync2_q) : (sync2_q & ~prev_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      option_q <= '1;
      tmr0_q   <= '0;
      t0if_q   <= 1'b0;
      ps_q     <= 8'd0;
      inh_q    <= 2'd0;
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      prev_q   <= 1'b0;
      edge_q   <= 1'b0;
    end else begin
      option_q <= option_d;
      tmr0_q   <= tmr0_d;
      t0if_q   <= t0if_d;
      ps_q     <= ps_d;
      inh_q    <= inh_d;
      sync1_q  <= t0cki;
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
      edge_q   <= edge_d;
    end
  end

  assign OPTION = option_q;
  assign TMR0   = tmr0_q;
  assign T0IF   = t0if_q;

endmodule
`default_nettype wire

// File: tb/tb_sfr_timer_bank.sv
`default_nettype none
// tb_sfr_timer_bank: table-driven and directed checks of the SFR/TMR0 bank.
module tb_sfr_timer_bank;

  logic        clk;
  logic        rst;
  logic [7:0]  W;
  logic [1:0]  tris_wr;
  logic        option_wr;
  logic        tmr0_wr;
  logic        cyc_en;
  logic        t0cki;
  logic        t0if_clr;
  logic [15:0] TRIS;
  logic [7:0]  OPTION;
  logic [7:0]  TMR0;
  logic        T0IF;

  int errors = 0;
  int checks = 0;

  sfr_timer_bank #(
    .DATA_W   (8),
    .NUM_PORTS(2),
    .TRIS_RST (8'hFF)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .W        (W),
    .tris_wr  (tris_wr),
    .option_wr(option_wr),
    .tmr0_wr  (tmr0_wr),
    .cyc_en   (cyc_en),
    .t0cki    (t0cki),
    .t0if_clr (t0if_clr),
    .TRIS     (TRIS),
    .OPTION   (OPTION),
    .TMR0     (TMR0),
    .T0IF     (T0IF)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  w;
    logic [1:0]  tw;
    logic        ow;
    logic        mw;
    logic        cyc;
    logic        clr;
    logic [15:0] e_tris;
    logic [7:0]  e_opt;
    logic [7:0]  e_tmr;
    logic        e_if;
  } vec_t;

  vec_t vt [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    W = 8'h00; tris_wr = 2'b00; option_wr = 1'b0; tmr0_wr = 1'b0;
    cyc_en = 1'b0; t0if_clr = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int exp_t;
    int falls;

    vt[0]  = '{8'h3C, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 16'h3CFF, 8'hFF, 8'h00, 1'b0};
    vt[1]  = '{8'h08, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 16'h3CFF, 8'h08, 8'h00, 1'b0};
    vt[2]  = '{8'hFD, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 16'h3CFF, 8'h08, 8'hFD, 1'b0};
    vt[3]  = '{8'h00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 16'h3CFF, 8'h08, 8'hFD, 1'b0};
    vt[4]  = '{8'h00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 16'h3CFF, 8'h08, 8'hFD, 1'b0};
    vt[5]  = '{8'h00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 16'h3CFF, 8'h08, 8'hFE, 1'b0};
    vt[6]  = '{8'h00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 16'h3CFF, 8'h08, 8'hFF, 1'b0};
    vt[7]  = '{8'h00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 16'h3CFF, 8'h08, 8'h00, 1'b1};
    vt[8]  = '{8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h3CFF, 8'h08, 8'h00, 1'b1};
    vt[9]  = '{8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 16'h3CFF, 8'h08, 8'h00, 1'b0};
    vt[10] = '{8'h00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 16'h3CFF, 8'h08, 8'h01, 1'b0};

    rst = 1'b0; t0cki = 1'b0;
    idle();
    step(); step();
    chk("rst_tris",   {16'h0, TRIS},   32'h0000FFFF);
    chk("rst_option", {24'h0, OPTION}, 32'h000000FF);
    chk("rst_tmr0",   {24'h0, TMR0},   32'h00000000);
    chk("rst_t0if",   {31'h0, T0IF},   32'h00000000);
    rst = 1'b1;

    // Table: TRIS write, internal count through overflow, flag clear.
    for (int i = 0; i < 11; i++) begin
      W = vt[i].w; tris_wr = vt[i].tw; option_wr = vt[i].ow; tmr0_wr = vt[i].mw;
      cyc_en = vt[i].cyc; t0if_clr = vt[i].clr;
      step();
      chk("tbl_tris",   {16'h0, TRIS},   {16'h0, vt[i].e_tris});
      chk("tbl_option", {24'h0, OPTION}, {24'h0, vt[i].e_opt});
      chk("tbl_tmr0",   {24'h0, TMR0},   {24'h0, vt[i].e_tmr});
      chk("tbl_t0if",   {31'h0, T0IF},   {31'h0, vt[i].e_if});
    end

    // Prescaler 1:8 on the internal source.
    idle(); W = 8'h02; option_wr = 1'b1;
    step();
    chk("ps_option", {24'h0, OPTION}, 32'h02);
    chk("ps_tmr0_start", {24'h0, TMR0}, 32'h01);
    idle(); cyc_en = 1'b1;
    for (int k = 0; k < 24; k++) begin
      step();
      exp_t = 1 + (k + 1) / 8;
      chk("ps_div8", {24'h0, TMR0}, exp_t);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      chk("ps_partial", {24'h0, TMR0}, 32'h04);
    end
    W = 8'h02; option_wr = 1'b1;
    step();
    chk("ps_restart_wr", {24'h0, TMR0}, 32'h04);
    option_wr = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("ps_restart", {24'h0, TMR0}, (k == 7) ? 32'h05 : 32'h04);
    end

    // External falling-edge counting, PSA bypassed.
    idle(); W = 8'h38; option_wr = 1'b1;
    step();
    idle(); W = 8'h00; tmr0_wr = 1'b1;
    step();
    chk("ext_tmr0_zero", {24'h0, TMR0}, 32'h00);
    idle();
    repeat (3) step();
    for (int s = 0; s < 46; s++) begin
      t0cki = (s < 40) && ((s % 8) < 4);
      step();
      falls = 0;
      for (int f = 4; f <= 36; f += 8)
        if (f + 3 <= s) falls++;
      chk("ext_count", {24'h0, TMR0}, falls);
    end

    // Write beats increment; overflow overridden sets no flag.
    idle(); W = 8'h08; option_wr = 1'b1;
    step();
    chk("pri_option", {24'h0, OPTION}, 32'h08);
    idle(); W = 8'hFF; tmr0_wr = 1'b1; t0if_clr = 1'b1;
    step();
    idle();
    repeat (3) step();
    chk("pri_tmr0_ff", {24'h0, TMR0}, 32'hFF);
    W = 8'h10; tmr0_wr = 1'b1; cyc_en = 1'b1;
    step();
    chk("pri_wr_tmr0", {24'h0, TMR0}, 32'h10);
    chk("pri_wr_t0if", {31'h0, T0IF}, 32'h0);

    // Flag set beats same-cycle clear.
    idle(); W = 8'hFF; tmr0_wr = 1'b1;
    step();
    idle();
    repeat (3) step();
    cyc_en = 1'b1; t0if_clr = 1'b1;
    step();
    chk("set_clr_tmr0", {24'h0, TMR0}, 32'h00);
    chk("set_clr_t0if", {31'h0, T0IF}, 32'h1);

    // Asynchronous reset mid-count.
    idle(); W = 8'h02; option_wr = 1'b1;
    step();
    idle(); W = 8'h55; tris_wr = 2'b01;
    step();
    idle(); cyc_en = 1'b1;
    repeat (3) step();
    chk("ar_pre_t0if", {31'h0, T0IF}, 32'h1);
    chk("ar_pre_tris", {16'h0, TRIS}, 32'h3C55);
    #3 rst = 1'b0;
    #1;
    chk("ar_tris",   {16'h0, TRIS},   32'hFFFF);
    chk("ar_option", {24'h0, OPTION}, 32'hFF);
    chk("ar_tmr0",   {24'h0, TMR0},   32'h00);
    chk("ar_t0if",   {31'h0, T0IF},   32'h0);
    idle();
    @(negedge clk);
    rst = 1'b1;
    W = 8'h08; option_wr = 1'b1;
    step();
    idle(); cyc_en = 1'b1;
    step();
    chk("post_rst_tick", {24'h0, TMR0}, 32'h01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
